// File: rtl/rx_ppe_igr_buf_pkg.sv
// rx_ppe_igr_buf_pkg: shared types and defaults for the RX PPE -> ingress
// post-PPE transfer block.
//   rx_ppe_igr_t       descriptor handed from PPE to ingress (valid + payload)
//   RX_PPE_IGR_DEPTH   project default for per-channel depth
//   rx_ppe_igr_ptr_w   pointer width for a channel's circular storage
package rx_ppe_igr_buf_pkg;

    localparam int unsigned RX_PPE_IGR_DEPTH = 8;
    localparam int unsigned QID_W            = 4;
    localparam int unsigned DESC_W           = 20;

    typedef struct packed {
        logic              valid;
        logic [QID_W-1:0]  qid;
        logic [DESC_W-1:0] desc;
    } rx_ppe_igr_t;

    // Storage holds depth-1 slots; keep at least one bit for the 1-slot case.
    function automatic int unsigned rx_ppe_igr_ptr_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/rx_ppe_igr_buf_if.sv
// rx_ppe_igr_buf_if: channel bundle between PPE, transfer buffer and ingress.
//   ppe_in[i]      PPE descriptor for channel i (push when .valid)
//   ppe_credit[i]  one-cycle credit pulse back to the PPE
//   igr_out[i]     registered head entry for channel i
//   igr_ready[i]   ingress accepts igr_out[i]
// Modports are from the buffer's point of view: ppe faces the PPE,
// igr faces ingress.
interface rx_ppe_igr_buf_if
    import rx_ppe_igr_buf_pkg::*;
#(
    parameter int unsigned N_INTF = 2
);

    rx_ppe_igr_t [N_INTF-1:0] ppe_in;
    logic        [N_INTF-1:0] ppe_credit;
    rx_ppe_igr_t [N_INTF-1:0] igr_out;
    logic        [N_INTF-1:0] igr_ready;

    modport ppe (input ppe_in, output ppe_credit);
    modport igr (output igr_out, input igr_ready);

endinterface

// File: rtl/rx_ppe_igr_chan_fifo.sv
// rx_ppe_igr_chan_fifo: one PPE -> ingress channel. DEPTH-1 circular slots
// plus a registered output stage; occupancy counts both.
//   cclk, rst    clock, synchronous active-high reset
//   ppe_in       incoming descriptor (push when .valid)
//   ppe_credit   pulse one cycle after each pop
//   igr_out      registered head entry, .valid = entry held
//   igr_ready    ingress pop strobe (qualified by igr_out.valid)
//   fifo_cnt     occupancy 0..DEPTH
//   ovf_err      sticky drop flag, cleared by ovf_clr (set wins)
module rx_ppe_igr_chan_fifo
    import rx_ppe_igr_buf_pkg::*;
#(
    parameter int unsigned DEPTH = RX_PPE_IGR_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             cclk,
    input  logic             rst,
    input  rx_ppe_igr_t      ppe_in,
    output logic             ppe_credit,
    output rx_ppe_igr_t      igr_out,
    input  logic             igr_ready,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             ovf_err,
    input  logic             ovf_clr
);

    localparam int unsigned SLOTS = DEPTH - 1;
    localparam int unsigned PTR_W = rx_ppe_igr_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);

    rx_ppe_igr_t      mem [SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    rx_ppe_igr_t      out_q;

    logic push_c;
    logic pop_c;
    logic full_c;
    logic accept_c;
    logic out_free_c;
    logic st_empty_c;
    logic load_head_c;
    logic load_push_c;
    logic st_wr_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Full channel still accepts when the head leaves in the same cycle.
    assign push_c      = ppe_in.valid;
    assign pop_c       = out_q.valid && igr_ready;
    assign full_c      = (cnt == CNT_W'(DEPTH));
    assign accept_c    = push_c && (!full_c || pop_c);
    assign out_free_c  = !out_q.valid || pop_c;
    // Storage occupancy is cnt minus the output register's entry.
    assign st_empty_c  = (cnt == CNT_W'(out_q.valid));
    assign load_head_c = out_free_c && !st_empty_c;
    assign load_push_c = out_free_c && st_empty_c && accept_c;
    assign st_wr_c     = accept_c && !load_push_c;

    // Control state, output register, credit and overflow flag.
    always_ff @(posedge cclk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            out_q      <= '0;
            ppe_credit <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (st_wr_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (load_head_c) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end else if (load_push_c) begin
                out_q <= ppe_in;
            end else if (pop_c) begin
                out_q.valid <= 1'b0;
            end
            cnt        <= cnt + CNT_W'(accept_c) - CNT_W'(pop_c);
            ppe_credit <= pop_c;
            if (push_c && full_c && !pop_c) begin
                ovf_err <= 1'b1;
            end else if (ovf_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

    // Payload storage; flushed logically through the pointers on reset.
    always_ff @(posedge cclk) begin
        if (st_wr_c) begin
            mem[wr_ptr] <= ppe_in;
        end
    end

    assign igr_out  = out_q;
    assign fifo_cnt = cnt;

endmodule

// File: rtl/rx_ppe_igr_buf.sv
// rx_ppe_igr_buf: N_INTF independent PPE -> ingress channels with
// per-channel buffering, ingress backpressure and PPE credit return.
//   cclk, rst   clock, synchronous active-high reset
//   ppe_bus     ppe_in / ppe_credit per channel
//   igr_bus     igr_out / igr_ready per channel
//   fifo_cnt    per-channel occupancy, channel i at [i*CNT_W +: CNT_W]
//   ovf_err     sticky per-channel overflow flag
//   ovf_clr     clears all ovf_err bits
module rx_ppe_igr_buf
    import rx_ppe_igr_buf_pkg::*;
#(
    parameter int unsigned N_INTF = 2,
    parameter int unsigned DEPTH  = RX_PPE_IGR_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    cclk,
    input  logic                    rst,
    rx_ppe_igr_buf_if.ppe           ppe_bus,
    rx_ppe_igr_buf_if.igr           igr_bus,
    output logic [N_INTF*CNT_W-1:0] fifo_cnt,
    output logic [N_INTF-1:0]       ovf_err,
    input  logic                    ovf_clr
);

    logic        [N_INTF-1:0] chan_credit;
    rx_ppe_igr_t [N_INTF-1:0] chan_out;

    // One fully independent channel per interface.
    for (genvar i = 0; i < N_INTF; i++) begin : g_chan
        rx_ppe_igr_chan_fifo #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .cclk       (cclk),
            .rst        (rst),
            .ppe_in     (ppe_bus.ppe_in[i]),
            .ppe_credit (chan_credit[i]),
            .igr_out    (chan_out[i]),
            .igr_ready  (igr_bus.igr_ready[i]),
            .fifo_cnt   (fifo_cnt[i*CNT_W +: CNT_W]),
            .ovf_err    (ovf_err[i]),
            .ovf_clr    (ovf_clr)
        );
    end

    assign ppe_bus.ppe_credit = chan_credit;
    assign igr_bus.igr_out    = chan_out;

endmodule

// File: tb/tb_rx_ppe_igr_buf.sv
module tb_rx_ppe_igr_buf;
    import rx_ppe_igr_buf_pkg::*;

    localparam int unsigned N_INTF = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int          N_RAND = 1000;

    logic                    cclk = 1'b0;
    logic                    rst;
    logic                    ovf_clr;
    logic [N_INTF*CNT_W-1:0] fifo_cnt;
    logic [N_INTF-1:0]       ovf_err;

    int checks = 0;
    int fails  = 0;

    rx_ppe_igr_buf_if #(.N_INTF(N_INTF)) bus ();

    rx_ppe_igr_buf #(
        .N_INTF (N_INTF),
        .DEPTH  (DEPTH)
    ) dut (
        .cclk     (cclk),
        .rst      (rst),
        .ppe_bus  (bus),
        .igr_bus  (bus),
        .fifo_cnt (fifo_cnt),
        .ovf_err  (ovf_err),
        .ovf_clr  (ovf_clr)
    );

    always #5 cclk = ~cclk;

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < int'(N_INTF); i++) bus.ppe_in[i] = '0;
    endtask

    function automatic rx_ppe_igr_t mk(input logic [19:0] d);
        rx_ppe_igr_t e;
        e.valid = 1'b1;
        e.qid   = d[3:0];
        e.desc  = d;
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return fifo_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic test_reset();
        rst = 1'b1; ovf_clr = 1'b0; bus.igr_ready = '0; idle();
        tick(); tick();
        checks++; if (fifo_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0h exp 0", fifo_cnt); end
        checks++; if (ovf_err !== '0) begin fails++; $display("FAIL reset_ovf: got %0b exp 0", ovf_err); end
        checks++; if (bus.ppe_credit !== '0) begin fails++; $display("FAIL reset_credit: got %0b exp 0", bus.ppe_credit); end
        checks++; if (bus.igr_out[0].valid !== 1'b0 || bus.igr_out[1].valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %0b%0b exp 00", bus.igr_out[1].valid, bus.igr_out[0].valid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        bus.igr_ready = 2'b01;
        bus.ppe_in[0] = mk(20'h00100);
        tick(); idle();
        checks++; if (bus.igr_out[0] !== mk(20'h00100)) begin fails++; $display("FAIL single_out: got %0h exp %0h", bus.igr_out[0], mk(20'h00100)); end
        checks++; if (cnt_of(0) !== CNT_W'(1)) begin fails++; $display("FAIL single_cnt1: got %0d exp 1", cnt_of(0)); end
        checks++; if (bus.ppe_credit[0] !== 1'b0) begin fails++; $display("FAIL single_early_credit: got %0b exp 0", bus.ppe_credit[0]); end
        tick();
        checks++; if (bus.igr_out[0].valid !== 1'b0) begin fails++; $display("FAIL single_valid_off: got %0b exp 0", bus.igr_out[0].valid); end
        checks++; if (bus.ppe_credit[0] !== 1'b1) begin fails++; $display("FAIL single_credit: got %0b exp 1", bus.ppe_credit[0]); end
        checks++; if (cnt_of(0) !== CNT_W'(0)) begin fails++; $display("FAIL single_cnt0: got %0d exp 0", cnt_of(0)); end
        tick();
        checks++; if (bus.ppe_credit[0] !== 1'b0) begin fails++; $display("FAIL single_credit_pulse: got %0b exp 0", bus.ppe_credit[0]); end
        bus.igr_ready = '0;
    endtask

    task automatic test_fill_overflow();
        bus.igr_ready = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            bus.ppe_in[1] = mk(20'h00200 + 20'(k));
            tick();
        end
        idle();
        checks++; if (cnt_of(1) !== CNT_W'(DEPTH)) begin fails++; $display("FAIL fill_cnt: got %0d exp %0d", cnt_of(1), DEPTH); end
        checks++; if (ovf_err[1] !== 1'b0) begin fails++; $display("FAIL fill_no_ovf: got %0b exp 0", ovf_err[1]); end
        bus.ppe_in[1] = mk(20'h002FF);
        tick(); idle();
        checks++; if (ovf_err[1] !== 1'b1) begin fails++; $display("FAIL drop_ovf: got %0b exp 1", ovf_err[1]); end
        checks++; if (cnt_of(1) !== CNT_W'(DEPTH)) begin fails++; $display("FAIL drop_cnt: got %0d exp %0d", cnt_of(1), DEPTH); end
        bus.igr_ready = 2'b10;
        for (int k = 0; k < int'(DEPTH); k++) begin
            checks++; if (bus.igr_out[1] !== mk(20'h00200 + 20'(k))) begin
                fails++; $display("FAIL drain_order[%0d]: got %0h exp %0h", k, bus.igr_out[1], mk(20'h00200 + 20'(k))); end
            tick();
            checks++; if (bus.ppe_credit[1] !== 1'b1) begin fails++; $display("FAIL drain_credit[%0d]: got %0b exp 1", k, bus.ppe_credit[1]); end
        end
        checks++; if (bus.igr_out[1].valid !== 1'b0 || cnt_of(1) !== CNT_W'(0)) begin
            fails++; $display("FAIL drain_empty: valid %0b cnt %0d exp 0 0", bus.igr_out[1].valid, cnt_of(1)); end
        checks++; if (ovf_err[1] !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b exp 1", ovf_err[1]); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf_err !== 2'b00) begin fails++; $display("FAIL ovf_clear: got %0b exp 00", ovf_err); end
        bus.igr_ready = '0;
    endtask

    task automatic test_full_push_pop();
        logic [19:0] exp_d;
        bus.igr_ready = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            bus.ppe_in[1] = mk(20'h00300 + 20'(k));
            tick();
        end
        idle();
        checks++; if (cnt_of(1) !== CNT_W'(DEPTH)) begin fails++; $display("FAIL fpp_fill_cnt: got %0d exp %0d", cnt_of(1), DEPTH); end
        bus.ppe_in[1] = mk(20'h003AA);
        bus.igr_ready = 2'b10;
        tick(); idle();
        bus.igr_ready = '0;
        checks++; if (cnt_of(1) !== CNT_W'(DEPTH)) begin fails++; $display("FAIL fpp_cnt: got %0d exp %0d", cnt_of(1), DEPTH); end
        checks++; if (ovf_err[1] !== 1'b0) begin fails++; $display("FAIL fpp_ovf: got %0b exp 0", ovf_err[1]); end
        checks++; if (bus.ppe_credit[1] !== 1'b1) begin fails++; $display("FAIL fpp_credit: got %0b exp 1", bus.ppe_credit[1]); end
        bus.igr_ready = 2'b10;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            exp_d = (k < int'(DEPTH)) ? 20'h00300 + 20'(k) : 20'h003AA;
            checks++; if (bus.igr_out[1] !== mk(exp_d)) begin
                fails++; $display("FAIL fpp_order[%0d]: got %0h exp %0h", k, bus.igr_out[1], mk(exp_d)); end
            tick();
        end
        checks++; if (cnt_of(1) !== CNT_W'(0)) begin fails++; $display("FAIL fpp_empty: got %0d exp 0", cnt_of(1)); end
        bus.igr_ready = '0;
    endtask

    task automatic test_reset_mid();
        bus.igr_ready = '0;
        for (int k = 0; k < 5; k++) begin
            bus.ppe_in[0] = mk(20'h00500 + 20'(k));
            tick();
        end
        idle();
        checks++; if (cnt_of(0) !== CNT_W'(5)) begin fails++; $display("FAIL rmid_cnt5: got %0d exp 5", cnt_of(0)); end
        rst = 1'b1;
        bus.igr_ready = 2'b11;
        tick();
        checks++; if (bus.igr_out[0].valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b exp 0", bus.igr_out[0].valid); end
        checks++; if (fifo_cnt !== '0) begin fails++; $display("FAIL rmid_cnt: got %0h exp 0", fifo_cnt); end
        checks++; if (bus.ppe_credit !== '0) begin fails++; $display("FAIL rmid_credit: got %0b exp 0", bus.ppe_credit); end
        rst = 1'b0;
        tick();
        checks++; if (bus.ppe_credit !== '0 || bus.igr_out[0].valid !== 1'b0) begin
            fails++; $display("FAIL rmid_post: credit %0b valid %0b exp 0 0", bus.ppe_credit, bus.igr_out[0].valid); end
        bus.ppe_in[0] = mk(20'h005AB);
        tick(); idle();
        checks++; if (bus.igr_out[0] !== mk(20'h005AB)) begin fails++; $display("FAIL rmid_first: got %0h exp %0h", bus.igr_out[0], mk(20'h005AB)); end
        tick();
        checks++; if (bus.ppe_credit[0] !== 1'b1) begin fails++; $display("FAIL rmid_first_credit: got %0b exp 1", bus.ppe_credit[0]); end
        bus.igr_ready = '0;
        tick();
    endtask

    task automatic test_ovf_clr();
        bus.igr_ready = '0;
        for (int k = 0; k <= int'(DEPTH); k++) begin
            bus.ppe_in[0] = mk(20'h00600 + 20'(k));
            tick();
        end
        idle();
        checks++; if (ovf_err !== 2'b01) begin fails++; $display("FAIL oc_set: got %0b exp 01", ovf_err); end
        bus.ppe_in[0] = mk(20'h006F1);
        ovf_clr = 1'b1;
        tick(); idle();
        ovf_clr = 1'b0;
        checks++; if (ovf_err !== 2'b01) begin fails++; $display("FAIL oc_set_wins: got %0b exp 01", ovf_err); end
        checks++; if (cnt_of(0) !== CNT_W'(DEPTH)) begin fails++; $display("FAIL oc_cnt: got %0d exp %0d", cnt_of(0), DEPTH); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf_err !== 2'b00) begin fails++; $display("FAIL oc_clear: got %0b exp 00", ovf_err); end
        bus.igr_ready = 2'b01;
        for (int k = 0; k < int'(DEPTH); k++) begin
            checks++; if (bus.igr_out[0] !== mk(20'h00600 + 20'(k))) begin
                fails++; $display("FAIL oc_order[%0d]: got %0h exp %0h", k, bus.igr_out[0], mk(20'h00600 + 20'(k))); end
            tick();
        end
        checks++; if (bus.igr_out[0].valid !== 1'b0) begin fails++; $display("FAIL oc_empty: got %0b exp 0", bus.igr_out[0].valid); end
        bus.igr_ready = '0;
        tick();
    endtask

    task automatic test_random();
        int pushed [N_INTF];
        int popped [N_INTF];
        int credits [N_INTF];
        int cred_seen [N_INTF];
        int cyc;
        logic r;
        logic [19:0] exp_d;
        for (int c = 0; c < int'(N_INTF); c++) begin
            pushed[c] = 0; popped[c] = 0; credits[c] = int'(DEPTH); cred_seen[c] = 0;
        end
        cyc = 0;
        while ((popped[0] < N_RAND || popped[1] < N_RAND) && cyc < 20000) begin
            for (int c = 0; c < int'(N_INTF); c++) begin
                credits[c]   += int'(bus.ppe_credit[c]);
                cred_seen[c] += int'(bus.ppe_credit[c]);
                r = ($urandom_range(0, 3) != 0);
                if (bus.igr_out[c].valid && r) begin
                    exp_d = {4'(c), 16'(popped[c])};
                    checks++; if (bus.igr_out[c] !== mk(exp_d)) begin
                        fails++; $display("FAIL rand_order ch%0d n%0d: got %0h exp %0h", c, popped[c], bus.igr_out[c], mk(exp_d)); end
                    popped[c]++;
                end
                bus.igr_ready[c] = r;
                if (pushed[c] < N_RAND && credits[c] > 0 && $urandom_range(0, 3) != 0) begin
                    bus.ppe_in[c] = mk({4'(c), 16'(pushed[c])});
                    credits[c]--;
                    pushed[c]++;
                end else begin
                    bus.ppe_in[c] = '0;
                end
            end
            tick();
            cyc++;
        end
        checks++; if (cyc >= 20000) begin fails++; $display("FAIL rand_timeout: popped %0d/%0d exp %0d", popped[0], popped[1], N_RAND); end
        for (int c = 0; c < int'(N_INTF); c++) cred_seen[c] += int'(bus.ppe_credit[c]);
        bus.igr_ready = '0; idle();
        tick();
        for (int c = 0; c < int'(N_INTF); c++) begin
            cred_seen[c] += int'(bus.ppe_credit[c]);
            checks++; if (cred_seen[c] != N_RAND) begin fails++; $display("FAIL rand_credits ch%0d: got %0d exp %0d", c, cred_seen[c], N_RAND); end
        end
        checks++; if (ovf_err !== 2'b00) begin fails++; $display("FAIL rand_ovf: got %0b exp 00", ovf_err); end
        checks++; if (fifo_cnt !== '0) begin fails++; $display("FAIL rand_cnt: got %0h exp 0", fifo_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        ovf_clr = 1'b0;
        bus.igr_ready = '0;
        idle();
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_ovf_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
